// File: rtl/servo_ramp_pkg.sv
// Shared constants, state encoding and position arithmetic helpers for servo_ramp.
// Timing values assume a 12 MHz system clock.
package servo_ramp_pkg;

   localparam int T_16ms = 192000;

   typedef enum logic {
      IDLE   = 1'b0,
      MOVING = 1'b1
   } state_t;

   // Magnitude of (a - b) in 9 bits, so a full 0..255 span never wraps.
   function automatic logic [8:0] abs_diff9(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] d;
      d = {1'b0, a} - {1'b0, b};
      return d[8] ? (9'd0 - d) : d;
   endfunction

   // Only called when |tgt - pos| > step, so the result stays inside 0..255.
   function automatic logic [7:0] step_toward(input logic [7:0] pos,
                                              input logic [7:0] tgt,
                                              input logic [7:0] step);
      return (tgt > pos) ? (pos + step) : (pos - step);
   endfunction

endpackage

// File: rtl/servo_ramp_tick_gen.sv
// Free-running modulo-TICK_CYCLES counter with synchronous clear.
// tick is high for the one cycle in which the counter holds TICK_CYCLES-1.
module servo_ramp_tick_gen
   import servo_ramp_pkg::*;
#(
   parameter int TICK_CYCLES = T_16ms
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = $clog2(TICK_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/servo_ramp.sv
// Slew-rate-limited servo position generator: walks pos toward an accepted
// target by STEP counts once per TICK_CYCLES clocks.
module servo_ramp
   import servo_ramp_pkg::*;
#(
   parameter int TICK_CYCLES = T_16ms,
   parameter int STEP        = 1,
   parameter int INIT_POS    = 128
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] target,
   input  logic       target_valid,
   output logic       target_ready,
   input  logic       stop,
   output logic [7:0] pos,
   output logic       busy,
   output logic       done
);

   localparam logic [7:0] STEP8 = 8'(STEP);
   localparam logic [7:0] INIT8 = 8'(INIT_POS);

   state_t     state_q, state_d;
   logic [7:0] pos_q, pos_d;
   logic [7:0] tgt_q, tgt_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       accept;
   logic       tick;

   assign target_ready = (state_q == IDLE);
   assign accept       = target_valid && target_ready;
   assign pos          = pos_q;
   assign busy         = busy_q;
   assign done         = done_q;

   // Counter is cleared on accept so the first step lands TICK_CYCLES after it.
   servo_ramp_tick_gen #(
      .TICK_CYCLES(TICK_CYCLES)
   ) u_tick_gen (
      .clk (clk),
      .rstn(rstn),
      .clr (accept),
      .tick(tick)
   );

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      tgt_d   = tgt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (accept) begin
               tgt_d = target;
               if (target == pos_q) begin
                  done_d = 1'b1;
               end else begin
                  state_d = MOVING;
                  busy_d  = 1'b1;
               end
            end
         end
         MOVING: begin
            // stop wins over a coincident tick: pos is frozen, no done.
            if (stop) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (tick) begin
               if (abs_diff9(tgt_q, pos_q) <= {1'b0, STEP8}) begin
                  pos_d   = tgt_q;
                  done_d  = 1'b1;
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  pos_d = step_toward(pos_q, tgt_q, STEP8);
               end
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         pos_q   <= INIT8;
         tgt_q   <= INIT8;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         tgt_q   <= tgt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule
